// File: rtl/mem_access_scheduler_pkg.sv
// mem_access_scheduler_pkg: FSM states, default parameters and the round-robin pick helper
package mem_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} msched_state_e;
  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_AW = 8;
  localparam int DEF_DW = 8;
  localparam int DEF_MEM_LAT = 1;
  // first set bit of req scanning upward from ptr+1, wrapping modulo n
  function automatic int rr_next(input logic [7:0] req, input int ptr, input int n = DEF_NUM_REQ);
    int r;
    logic f;
    r = 0;
    f = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!f && k <= n && req[3'((ptr + k) % n)]) begin
        r = (ptr + k) % n;
        f = 1'b1;
      end
    end
    return r;
  endfunction
endpackage

// File: rtl/mem_access_scheduler_if.sv
// mem_access_scheduler_if: requester and memory-port signals of the scheduler
interface mem_access_scheduler_if
  import mem_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] req_rw;
  logic [NUM_REQ*AW-1:0] req_addr;
  logic [NUM_REQ*DW-1:0] req_wdata;
  logic [NUM_REQ-1:0] ack;
  logic [DW-1:0] rdata;
  logic busy;
  logic mem_valid;
  logic mem_rw;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  modport master (
    output req, req_rw, req_addr, req_wdata, mem_rdata,
    input ack, rdata, busy, mem_valid, mem_rw, mem_addr, mem_wdata
  );
  modport slave (
    input req, req_rw, req_addr, req_wdata, mem_rdata,
    output ack, rdata, busy, mem_valid, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_access_scheduler_rr_pick.sv
// mem_sched_rr_pick: combinational round-robin winner selection after the last granted index
module mem_sched_rr_pick
  import mem_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      gnt_idx,
  output logic               any_req
);
  always_comb begin
    gnt_idx = IW'(rr_next(8'(req), int'(ptr), NUM_REQ));
    any_req = |req;
  end
endmodule

// File: rtl/mem_access_scheduler.sv
// mem_access_scheduler: round-robin sharing of one single-port memory among NUM_REQ requesters.
// Define MEM_SCHED_STATS_EN to add saturating per-requester grant counters on grant_cnt.
module mem_access_scheduler
  import mem_sched_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int AW = DEF_AW,
  parameter int DW = DEF_DW,
  parameter int MEM_LAT = DEF_MEM_LAT
) (
  input logic clk,
  input logic reset,
`ifdef MEM_SCHED_STATS_EN
  output logic [NUM_REQ*16-1:0] grant_cnt,
`endif
  mem_access_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int LW = $clog2(MEM_LAT + 1);
  msched_state_e r_state;
  logic [IW-1:0] r_ptr;
  logic [IW-1:0] r_idx;
  logic [IW-1:0] w_gnt;
  logic [LW-1:0] r_cnt;
  logic [NUM_REQ-1:0] r_ack;
  logic [DW-1:0] r_rdata;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] w_wdata;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr;
  logic r_busy;
  logic r_valid;
  logic r_rw;
  logic w_any;

  mem_sched_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req(bus.req),
    .ptr(r_ptr),
    .gnt_idx(w_gnt),
    .any_req(w_any)
  );

  always_comb begin
    w_addr = '0;
    w_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_addr = (IW'(i) == w_gnt) ? bus.req_addr[i*AW +: AW] : w_addr;
      w_wdata = (IW'(i) == w_gnt) ? bus.req_wdata[i*DW +: DW] : w_wdata;
    end
  end

  // mem_rw/mem_addr/mem_wdata double as the latched transaction fields
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= IW'(NUM_REQ - 1);
      r_idx <= '0;
      r_cnt <= '0;
      r_ack <= '0;
      r_rdata <= '0;
      r_busy <= 1'b0;
      r_valid <= 1'b0;
      r_rw <= 1'b0;
      r_addr <= '0;
      r_wdata <= '0;
    end else begin
      r_ack <= '0;
      r_valid <= 1'b0;
      case (r_state)
        IDLE: if (w_any) begin
          r_state <= ISSUE;
          r_idx <= w_gnt;
          r_rw <= bus.req_rw[w_gnt];
          r_addr <= w_addr;
          r_wdata <= w_wdata;
          r_valid <= 1'b1;
          r_busy <= 1'b1;
        end
        ISSUE: if (r_rw) begin
          r_state <= WAIT;
          r_cnt <= LW'(MEM_LAT);
        end else begin
          r_state <= ACK;
          r_ack <= NUM_REQ'(1) << r_idx;
        end
        WAIT: if (r_cnt == LW'(1)) begin
          r_rdata <= bus.mem_rdata;
          r_state <= ACK;
          r_ack <= NUM_REQ'(1) << r_idx;
        end else begin
          r_cnt <= r_cnt - LW'(1);
        end
        ACK: begin
          r_ptr <= r_idx;
          r_busy <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_cnt <= '0;
    end else if (r_state == ACK) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (IW'(i) == r_idx && grant_cnt[i*16 +: 16] != 16'hFFFF) grant_cnt[i*16 +: 16] <= grant_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`endif

  assign bus.ack = r_ack;
  assign bus.rdata = r_rdata;
  assign bus.busy = r_busy;
  assign bus.mem_valid = r_valid;
  assign bus.mem_rw = r_rw;
  assign bus.mem_addr = r_addr;
  assign bus.mem_wdata = r_wdata;
endmodule

// File: tb/tb_mem_access_scheduler.sv
// tb_mem_access_scheduler: vector table, directed corner sequences and random traffic against a timeline model
module tb_mem_access_scheduler;
  localparam int N = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_access_scheduler_if #(.NUM_REQ(N), .AW(AW), .DW(DW)) bus ();
`ifdef MEM_SCHED_STATS_EN
  logic [N*16-1:0] grant_cnt;
`endif

  mem_access_scheduler #(.NUM_REQ(N), .AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk),
    .reset(reset),
`ifdef MEM_SCHED_STATS_EN
    .grant_cnt(grant_cnt),
`endif
    .bus(bus)
  );

  logic [7:0] mem [256];
  logic [7:0] pipe [LAT];
  always @(posedge clk) begin
    if (bus.mem_valid && !bus.mem_rw) mem[bus.mem_addr] <= bus.mem_wdata;
    pipe[0] <= mem[bus.mem_addr];
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign bus.mem_rdata = pipe[LAT-1];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [N-1:0] drv_req = '0;
  logic [N-1:0] drv_rw = '0;
  logic [N*AW-1:0] drv_addr = '0;
  logic [N*DW-1:0] drv_wd = '0;
  logic [N-1:0] last_ack;

  // transaction timeline model: cycle of grant, issue and ack for the one in flight
  int m_start = -10;
  int m_issue_at = -10;
  int m_ack_at = -10;
  int m_idx = 0;
  int m_ptr = N - 1;
  logic m_rw;
  logic [7:0] m_addr, m_wd, m_rd;
  bit m_rd_ok;
  logic [7:0] ref_mem [256];
  bit ref_ok [256];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endfunction

  task automatic decide();
    int w;
    w = -1;
    for (int k = 1; k <= N; k++) if (w < 0 && drv_req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    m_idx = w;
    m_rw = drv_rw[w];
    m_addr = drv_addr[w*AW +: AW];
    m_wd = drv_wd[w*DW +: DW];
    m_start = cyc;
    m_issue_at = cyc + 1;
    m_ack_at = cyc + (m_rw ? 2 + LAT : 2);
    if (m_rw) begin
      m_rd = ref_mem[m_addr];
      m_rd_ok = ref_ok[m_addr];
    end else begin
      ref_mem[m_addr] = m_wd;
      ref_ok[m_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    logic [N-1:0] eack;
    @(negedge clk);
    cyc++;
    eack = (cyc == m_ack_at) ? N'(1) << m_idx : '0;
    chk("ack", 32'(bus.ack), 32'(eack));
    chk("mem_valid", 32'(bus.mem_valid), 32'(cyc == m_issue_at));
    chk("busy", 32'(bus.busy), 32'(cyc > m_start && cyc <= m_ack_at));
    if (cyc == m_issue_at) begin
      chk("mem_rw", 32'(bus.mem_rw), 32'(m_rw));
      chk("mem_addr", 32'(bus.mem_addr), 32'(m_addr));
      if (!m_rw) chk("mem_wdata", 32'(bus.mem_wdata), 32'(m_wd));
    end
    if (cyc == m_ack_at) begin
      m_ptr = m_idx;
      if (m_rw && m_rd_ok) chk("rdata", 32'(bus.rdata), 32'(m_rd));
    end
    last_ack = bus.ack;
    drv_req &= ~bus.ack;
    bus.req = drv_req;
    bus.req_rw = drv_rw;
    bus.req_addr = drv_addr;
    bus.req_wdata = drv_wd;
    if (cyc > m_ack_at && drv_req != '0) decide();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drv_req = '0;
    bus.req = '0;
    @(negedge clk);
    cyc++;
    chk("rst_ack", 32'(bus.ack), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mem_valid", 32'(bus.mem_valid), 0);
    chk("rst_mem_rw", 32'(bus.mem_rw), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_rdata", 32'(bus.rdata), 0);
`ifdef MEM_SCHED_STATS_EN
    chk("rst_grant_cnt", 32'(grant_cnt[31:0] | grant_cnt[63:32]), 0);
`endif
    reset = 1'b0;
    m_ptr = N - 1;
    m_start = -10;
    m_issue_at = -10;
    m_ack_at = -10;
  endtask

  task automatic txn(input int idx, input logic rw, input logic [7:0] addr, input logic [7:0] wd,
                     output int lat, output logic [N-1:0] ackv, output logic [7:0] rd);
    int t0;
    bit done;
    drv_req = '0;
    drv_req[idx] = 1'b1;
    drv_rw[idx] = rw;
    drv_addr[idx*AW +: AW] = addr;
    drv_wd[idx*DW +: DW] = wd;
    t0 = cyc + 1;
    done = 0;
    lat = -1;
    ackv = '0;
    rd = '0;
    for (int k = 0; k < 20 && !done; k++) begin
      tick();
      if (last_ack != '0) begin
        done = 1;
        lat = cyc - t0;
        ackv = last_ack;
        rd = bus.rdata;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout idx=%0d got=no_ack exp=ack", idx);
    end
  endtask

  typedef struct {
    int idx;
    logic rw;
    logic [7:0] addr;
    logic [7:0] wd;
    logic [7:0] exp_rd;
    int exp_lat;
  } vec_t;

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl [8];
    int lat;
    logic [N-1:0] ackv;
    logic [7:0] rd;
    int order [$];
    int n3, nmv;
    bit got;
    tbl[0] = '{2, 1'b0, 8'h10, 8'hA5, 8'h00, 2};
    tbl[1] = '{1, 1'b1, 8'h10, 8'h00, 8'hA5, 2 + LAT};
    tbl[2] = '{0, 1'b0, 8'hFF, 8'h3C, 8'h00, 2};
    tbl[3] = '{3, 1'b1, 8'hFF, 8'h00, 8'h3C, 2 + LAT};
    tbl[4] = '{3, 1'b0, 8'h00, 8'h81, 8'h00, 2};
    tbl[5] = '{0, 1'b1, 8'h00, 8'h00, 8'h81, 2 + LAT};
    tbl[6] = '{1, 1'b0, 8'h10, 8'h5A, 8'h00, 2};
    tbl[7] = '{2, 1'b1, 8'h10, 8'h00, 8'h5A, 2 + LAT};
    for (int i = 0; i < 256; i++) ref_ok[i] = 1'b0;
    bus.req = '0;
    bus.req_rw = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    do_reset();

    for (int i = 0; i < 8; i++) begin
      txn(tbl[i].idx, tbl[i].rw, tbl[i].addr, tbl[i].wd, lat, ackv, rd);
      chk("tbl_lat", 32'(lat), 32'(tbl[i].exp_lat));
      chk("tbl_ack", 32'(ackv), 32'(N'(1) << tbl[i].idx));
      if (tbl[i].rw) chk("tbl_rdata", 32'(rd), 32'(tbl[i].exp_rd));
    end

    do_reset();
    drv_req = '1;
    drv_rw = '0;
    for (int i = 0; i < N; i++) begin
      drv_addr[i*AW +: AW] = 8'(8'h40 + i);
      drv_wd[i*DW +: DW] = 8'(8'hC0 + i);
    end
    for (int k = 0; k < 40; k++) begin
      tick();
      for (int i = 0; i < N; i++) if (last_ack[i]) order.push_back(i);
      drv_req = '1;
    end
    chk("rr_count", 32'(order.size() >= 8), 1);
    for (int k = 0; k < 8 && k < order.size(); k++) chk("rr_order", 32'(order[k]), 32'(k % N));
    drv_req = '0;
    repeat (4) tick();

    drv_req = '0;
    drv_req[0] = 1'b1;
    drv_rw[0] = 1'b0;
    tick();
    drv_req[3] = 1'b1;
    drv_rw[3] = 1'b0;
    n3 = 0;
    nmv = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      drv_req[3] = 1'b0;
      n3 += int'(last_ack[3]);
      nmv += int'(bus.mem_valid);
    end
    chk("withdraw_ack3", 32'(n3), 0);
    chk("withdraw_mem_valid", 32'(nmv), 1);

    drv_req = '0;
    drv_req[1] = 1'b1;
    drv_rw[1] = 1'b1;
    drv_addr[1*AW +: AW] = 8'h10;
    tick();
    tick();
    tick();
    do_reset();
    drv_req = '1;
    drv_rw = '0;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick();
      if (last_ack != '0) begin
        got = 1;
        chk("post_reset_first", 32'(last_ack), 1);
      end
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL post_reset_first got=no_ack exp=1");
    end

    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) begin
        if (drv_req[i]) begin
          if (!(m_idx == i && m_ack_at >= cyc + 1) && $urandom_range(0, 15) == 0) drv_req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          drv_req[i] = 1'b1;
          drv_rw[i] = 1'($urandom_range(0, 1));
          drv_addr[i*AW +: AW] = 8'($urandom_range(0, 15));
          drv_wd[i*DW +: DW] = 8'($urandom);
        end
      end
      tick();
    end
    drv_req = '0;
    repeat (8) tick();

`ifdef MEM_SCHED_STATS_EN
    do_reset();
    for (int k = 0; k < 5; k++) txn(0, 1'b0, 8'(8'h80 + k), 8'(k), lat, ackv, rd);
    for (int k = 0; k < 2; k++) txn(3, 1'b0, 8'(8'h90 + k), 8'(k), lat, ackv, rd);
    tick();
    chk("grant_cnt0", 32'(grant_cnt[0 +: 16]), 5);
    chk("grant_cnt1", 32'(grant_cnt[16 +: 16]), 0);
    chk("grant_cnt2", 32'(grant_cnt[32 +: 16]), 0);
    chk("grant_cnt3", 32'(grant_cnt[48 +: 16]), 2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
